// File: rtl/tmds_pkg.sv
// ----------------------------------------------------------------------------
// tmds_pkg
// Shared definitions for the TMDS encoder array:
//   - period mode encoding (tmds_mode_e)
//   - 10-bit guard-band code words
//   - control-period (2b->10b) and TERC4 (4b->10b) lookup functions
// ----------------------------------------------------------------------------
package tmds_pkg;

   typedef enum logic [2:0] {
      CONTROL      = 3'd0,
      VIDEO        = 3'd1,
      VIDEO_GUARD  = 3'd2,
      ISLAND       = 3'd3,
      ISLAND_GUARD = 3'd4
   } tmds_mode_e;

   // Guard-band code words
   localparam logic [9:0] GUARD_VIDEO_CH02 = 10'b1011001100;
   localparam logic [9:0] GUARD_CH12       = 10'b0100110011;

   // Control code 00, also the reset value of every lane
   localparam logic [9:0] CTRL_CODE_00     = 10'b1101010100;

   function automatic logic [9:0] ctrl_code(input logic [1:0] c);
      logic [9:0] code;
      case (c)
         2'b00:   code = 10'b1101010100;
         2'b01:   code = 10'b0010101011;
         2'b10:   code = 10'b0101010100;
         default: code = 10'b1010101011;
      endcase
      return code;
   endfunction

   function automatic logic [9:0] terc4(input logic [3:0] d);
      logic [9:0] code;
      case (d)
         4'h0:    code = 10'b1010011100;
         4'h1:    code = 10'b1001100011;
         4'h2:    code = 10'b1011100100;
         4'h3:    code = 10'b1011100010;
         4'h4:    code = 10'b0101110001;
         4'h5:    code = 10'b0100011110;
         4'h6:    code = 10'b0110001110;
         4'h7:    code = 10'b0100111100;
         4'h8:    code = 10'b1011001100;
         4'h9:    code = 10'b0100111001;
         4'hA:    code = 10'b0110011100;
         4'hB:    code = 10'b1011000110;
         4'hC:    code = 10'b1010001110;
         4'hD:    code = 10'b1001110001;
         4'hE:    code = 10'b0101100011;
         default: code = 10'b1011000011;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/tmds_encoder_array_lane.sv
// ----------------------------------------------------------------------------
// tmds_lane_encoder
// One TMDS lane: stage 1 computes the 9-bit transition-minimised word and
// the non-video code word; stage 2 applies DC balance (video) or forwards
// the code word, and holds the lane's running disparity.
// Optional: TMDS_DISPARITY_MON_EN exposes the registered disparity.
//
// Ports:
//   i_clk     pixel clock
//   i_rst_n   synchronous active-low reset
//   i_ce      clock enable (low = hold all state)
//   i_mode    period mode (tmds_pkg encoding)
//   i_video   8-bit video byte
//   i_island  4-bit data-island nibble
//   i_ctrl    2-bit control bits
//   o_tmds    10-bit encoded symbol
//   o_cnt     registered disparity (only with TMDS_DISPARITY_MON_EN)
// ----------------------------------------------------------------------------
module tmds_lane_encoder
   import tmds_pkg::*;
#(
   parameter int unsigned CHANNEL = 0
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_ce,
   input  logic [2:0] i_mode,
   input  logic [7:0] i_video,
   input  logic [3:0] i_island,
   input  logic [1:0] i_ctrl,
   output logic [9:0] o_tmds
`ifdef TMDS_DISPARITY_MON_EN
   ,
   output logic [4:0] o_cnt
`endif
);

   // ---------------- stage 1 combinational ----------------
   logic [3:0] w_n1d;
   logic       w_use_xnor;
   logic [8:0] w_qm;
   logic [3:0] w_n1qm;
   logic [9:0] w_code;

   always_comb begin
      w_n1d = '0;
      for (int unsigned i = 1; i < 8; i++) begin
         w_n1d = w_n1d + {3'b000, i_video[i]};
      end
      w_use_xnor = (w_n1d > 4'd3);

      w_qm    = '0;
      w_qm[0] = i_video[0];
      for (int unsigned i = 1; i < 8; i++) begin
         w_qm[i] = w_use_xnor ? ~(w_qm[i-1] ^ i_video[i]) : (w_qm[i-1] ^ i_video[i]);
      end
      w_qm[8] = ~w_use_xnor;

      w_n1qm = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         w_n1qm = w_n1qm + {3'b000, w_qm[i]};
      end
   end

   always_comb begin
      w_code = '0;
      case (i_mode)
         CONTROL: w_code = ctrl_code(i_ctrl);
         ISLAND:  w_code = terc4(i_island);
         VIDEO_GUARD: begin
            if (CHANNEL == 0 || CHANNEL == 2) w_code = GUARD_VIDEO_CH02;
            else if (CHANNEL == 1)            w_code = GUARD_CH12;
            else                              w_code = '0;
         end
         ISLAND_GUARD: begin
            if (CHANNEL == 0)                      w_code = terc4({2'b11, i_ctrl});
            else if (CHANNEL == 1 || CHANNEL == 2) w_code = GUARD_CH12;
            else                                   w_code = '0;
         end
         default: w_code = '0;
      endcase
   end

   // ---------------- stage 1 registers ----------------
   logic [2:0] r_mode;
   logic [8:0] r_qm;
   logic [3:0] r_n1qm;
   logic [9:0] r_code;

   // ---------------- stage 2 combinational ----------------
   logic signed [4:0] r_cnt;
   logic [9:0]        r_tmds;
   logic signed [4:0] w_n1s;
   logic signed [4:0] w_diff;     // N1 - N0
   logic signed [4:0] w_q8x2;     // 2*q_m[8]
   logic signed [4:0] w_nq8x2;    // 2*~q_m[8]
   logic [9:0]        w_vid;
   logic signed [4:0] w_cnt_nxt;

   always_comb begin
      w_n1s   = {1'b0, r_n1qm};
      w_diff  = w_n1s - (5'sd8 - w_n1s);
      w_q8x2  = {3'b000, r_qm[8], 1'b0};
      w_nq8x2 = {3'b000, ~r_qm[8], 1'b0};
      w_vid     = '0;
      w_cnt_nxt = r_cnt;
      if (r_cnt == 5'sd0 || r_n1qm == 4'd4) begin
         w_vid     = {~r_qm[8], r_qm[8], r_qm[8] ? r_qm[7:0] : ~r_qm[7:0]};
         w_cnt_nxt = r_qm[8] ? (r_cnt + w_diff) : (r_cnt - w_diff);
      end else if ((r_cnt > 5'sd0 && r_n1qm > 4'd4) ||
                   (r_cnt < 5'sd0 && r_n1qm < 4'd4)) begin
         w_vid     = {1'b1, r_qm[8], ~r_qm[7:0]};
         w_cnt_nxt = r_cnt + w_q8x2 - w_diff;
      end else begin
         w_vid     = {1'b0, r_qm[8], r_qm[7:0]};
         w_cnt_nxt = r_cnt + w_diff - w_nq8x2;
      end
   end

   // ---------------- pipeline registers ----------------
   // The stage-1 code register resets to control code 00 so that the first
   // enabled cycle after reset keeps emitting the reset symbol.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_mode <= CONTROL;
         r_qm   <= '0;
         r_n1qm <= '0;
         r_code <= CTRL_CODE_00;
         r_cnt  <= '0;
         r_tmds <= CTRL_CODE_00;
      end else if (i_ce) begin
         r_mode <= i_mode;
         r_qm   <= w_qm;
         r_n1qm <= w_n1qm;
         r_code <= w_code;
         if (r_mode == VIDEO) begin
            r_tmds <= w_vid;
            r_cnt  <= w_cnt_nxt;
         end else begin
            r_tmds <= r_code;
            r_cnt  <= '0;
         end
      end
   end

   assign o_tmds = r_tmds;
`ifdef TMDS_DISPARITY_MON_EN
   assign o_cnt  = r_cnt;
`endif

endmodule

// File: rtl/tmds_encoder_array.sv
// ----------------------------------------------------------------------------
// tmds_encoder_array
// NUM_CHANNELS TMDS lane encoders sharing one period mode, with clock enable
// and a fixed two-stage pipeline (input sample to tmds = 2 enabled cycles).
// Optional: define TMDS_DISPARITY_MON_EN to add the disparity_mon output.
//
// Ports:
//   clk_pixel         pixel clock
//   reset_n           synchronous active-low reset (wins over ce)
//   ce                clock enable
//   mode              period mode, shared by all lanes
//   video_data        lane k at [8k+7:8k]
//   data_island_data  lane k at [4k+3:4k]
//   control_data      lane k at [2k+1:2k]
//   tmds              lane k at [10k+9:10k]
//   disparity_mon     lane k at [5k+4:5k] (only with TMDS_DISPARITY_MON_EN)
// ----------------------------------------------------------------------------
module tmds_encoder_array
   import tmds_pkg::*;
#(
   parameter int unsigned NUM_CHANNELS = 3
) (
   input  logic                      clk_pixel,
   input  logic                      reset_n,
   input  logic                      ce,
   input  logic [2:0]                mode,
   input  logic [8*NUM_CHANNELS-1:0] video_data,
   input  logic [4*NUM_CHANNELS-1:0] data_island_data,
   input  logic [2*NUM_CHANNELS-1:0] control_data,
   output logic [10*NUM_CHANNELS-1:0] tmds
`ifdef TMDS_DISPARITY_MON_EN
   ,
   output logic [5*NUM_CHANNELS-1:0] disparity_mon
`endif
);

   for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_lane
      tmds_lane_encoder #(
         .CHANNEL (k)
      ) u_lane (
         .i_clk    (clk_pixel),
         .i_rst_n  (reset_n),
         .i_ce     (ce),
         .i_mode   (mode),
         .i_video  (video_data[8*k +: 8]),
         .i_island (data_island_data[4*k +: 4]),
         .i_ctrl   (control_data[2*k +: 2]),
         .o_tmds   (tmds[10*k +: 10])
`ifdef TMDS_DISPARITY_MON_EN
         ,
         .o_cnt    (disparity_mon[5*k +: 5])
`endif
      );
   end

endmodule

// File: tb/tb_tmds_encoder_array.sv
// ----------------------------------------------------------------------------
// tb_tmds_encoder_array
// Directed-vector bench for tmds_encoder_array (NUM_CHANNELS = 3).
// Expected symbols and disparities are hand-computed constants.
// ----------------------------------------------------------------------------
module tb_tmds_encoder_array;

   localparam int unsigned N = 3;

   localparam logic [9:0] CTL0 = 10'b1101010100;
   localparam logic [9:0] CTL2 = 10'b0101010100;
   localparam logic [9:0] CTL3 = 10'b1010101011;
   localparam logic [9:0] GV   = 10'b1011001100;
   localparam logic [9:0] GB   = 10'b0100110011;

   localparam logic [4:0] M8 = 5'b11000;  // -8
   localparam logic [4:0] M6 = 5'b11010;  // -6
   localparam logic [4:0] M2 = 5'b11110;  // -2
   localparam logic [4:0] P2 = 5'b00010;
   localparam logic [4:0] P4 = 5'b00100;
   localparam logic [4:0] Z  = 5'b00000;

   logic            clk_pixel;
   logic            reset_n;
   logic            ce;
   logic [2:0]      mode;
   logic [8*N-1:0]  video_data;
   logic [4*N-1:0]  data_island_data;
   logic [2*N-1:0]  control_data;
   logic [10*N-1:0] tmds;
`ifdef TMDS_DISPARITY_MON_EN
   logic [5*N-1:0]  disparity_mon;
`endif

   int n_total;
   int n_bad;

   tmds_encoder_array #(
      .NUM_CHANNELS (N)
   ) dut (
      .clk_pixel        (clk_pixel),
      .reset_n          (reset_n),
      .ce               (ce),
      .mode             (mode),
      .video_data       (video_data),
      .data_island_data (data_island_data),
      .control_data     (control_data),
      .tmds             (tmds)
`ifdef TMDS_DISPARITY_MON_EN
      ,
      .disparity_mon    (disparity_mon)
`endif
   );

   initial clk_pixel = 1'b0;
   always #5 clk_pixel = ~clk_pixel;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic chk_mon(input string tag, input logic [14:0] exp);
`ifdef TMDS_DISPARITY_MON_EN
      chk(tag, {17'd0, disparity_mon}, {17'd0, exp});
`else
      if (exp === 15'h7fff) $display("unused %s", tag);
`endif
   endtask

   task automatic step;
      @(posedge clk_pixel);
      #1;
   endtask

   task automatic drive(input logic [2:0] m, input logic [23:0] vd,
                        input logic [11:0] di, input logic [5:0] cd);
      mode             = m;
      video_data       = vd;
      data_island_data = di;
      control_data     = cd;
   endtask

   initial begin
      n_total = 0;
      n_bad   = 0;
      reset_n = 1'b0;
      ce      = 1'b1;
      drive(3'd0, 24'h0, 12'h0, 6'h0);
      step;
      step;
      chk("reset_tmds", {2'b00, tmds}, {2'b00, CTL0, CTL0, CTL0});
      chk_mon("reset_mon", {Z, Z, Z});

      // control codes, lanes 0/1/2 = 00/10/11
      reset_n = 1'b1;
      drive(3'd0, 24'h0, 12'h0, {2'b11, 2'b10, 2'b00});
      step;
      chk("post_reset", {2'b00, tmds}, {2'b00, CTL0, CTL0, CTL0});
      drive(3'd1, 24'h000000, 12'h0, 6'h0);           // s1
      step;
      chk("control", {2'b00, tmds}, {2'b00, CTL3, CTL2, CTL0});
      chk_mon("control_mon", {Z, Z, Z});
      drive(3'd1, 24'h000000, 12'h0, 6'h0);           // s2
      step;
      chk("video00_a", {2'b00, tmds}, {2'b00, {3{10'b0100000000}}});
      chk_mon("video00_a_mon", {M8, M8, M8});
      drive(3'd3, 24'h0, {4'hF, 4'h1, 4'h0}, 6'h0);   // s3
      step;
      chk("video00_b", {2'b00, tmds}, {2'b00, {3{10'b1111111111}}});
      chk_mon("video00_b_mon", {P2, P2, P2});
      drive(3'd3, 24'h0, {4'h0, 4'hD, 4'hF}, 6'h0);   // s4
      step;
      chk("island_a", {2'b00, tmds}, {2'b00, 10'b1011000011, 10'b1001100011, 10'b1010011100});
      chk_mon("island_mon", {Z, Z, Z});
      drive(3'd4, 24'h0, 12'h0, {2'b00, 2'b00, 2'b01}); // s5
      step;
      chk("island_b", {2'b00, tmds}, {2'b00, 10'b1010011100, 10'b1001110001, 10'b1011000011});
      drive(3'd2, 24'h0, 12'h0, 6'h0);                // s6
      step;
      chk("island_guard", {2'b00, tmds}, {2'b00, GB, GB, 10'b1001110001});
      drive(3'd1, {8'h55, 8'hFF, 8'h00}, 12'h0, 6'h0); // s7
      step;
      chk("video_guard", {2'b00, tmds}, {2'b00, GV, GB, GV});
      drive(3'd1, {8'h55, 8'hFF, 8'h00}, 12'h0, 6'h0); // s8
      step;
      chk("video_mix_a", {2'b00, tmds}, {2'b00, 10'b0100110011, 10'b1000000000, 10'b0100000000});
      chk_mon("video_mix_a_mon", {Z, M8, M8});
      drive(3'd1, {8'h55, 8'hFF, 8'h00}, 12'h0, 6'h0); // s9
      step;
      chk("video_mix_b", {2'b00, tmds}, {2'b00, 10'b0100110011, 10'b0011111111, 10'b1111111111});
      chk_mon("video_mix_b_mon", {Z, M2, P2});

      // stall: inputs changed while ce low must be ignored
      ce = 1'b0;
      drive(3'd0, 24'hAAAAAA, 12'h555, 6'h3F);
      step;
      chk("stall_1", {2'b00, tmds}, {2'b00, 10'b0100110011, 10'b0011111111, 10'b1111111111});
      chk_mon("stall_1_mon", {Z, M2, P2});
      step;
      chk("stall_2", {2'b00, tmds}, {2'b00, 10'b0100110011, 10'b0011111111, 10'b1111111111});
      chk_mon("stall_2_mon", {Z, M2, P2});
      ce = 1'b1;
      drive(3'd1, {8'h55, 8'hFF, 8'h00}, 12'h0, 6'h0); // s10
      step;
      chk("after_stall", {2'b00, tmds}, {2'b00, 10'b0100110011, 10'b0011111111, 10'b0100000000});
      chk_mon("after_stall_mon", {Z, P4, M6});

      // reset in the middle of a video period
      reset_n = 1'b0;
      drive(3'd1, {8'h55, 8'hFF, 8'h00}, 12'h0, 6'h0); // s11
      step;
      chk("mid_reset", {2'b00, tmds}, {2'b00, CTL0, CTL0, CTL0});
      chk_mon("mid_reset_mon", {Z, Z, Z});
      reset_n = 1'b1;
      drive(3'd1, {8'h55, 8'hFF, 8'h00}, 12'h0, 6'h0); // s12
      step;
      chk("release", {2'b00, tmds}, {2'b00, CTL0, CTL0, CTL0});
      drive(3'd5, 24'h0, 12'h0, 6'h0);                 // s13
      step;
      chk("video_fresh", {2'b00, tmds}, {2'b00, 10'b0100110011, 10'b1000000000, 10'b0100000000});
      chk_mon("video_fresh_mon", {Z, M8, M8});
      drive(3'd0, 24'h0, 12'h0, 6'h0);
      step;
      chk("mode5", {2'b00, tmds}, {2'b00, 30'd0});
      chk_mon("mode5_mon", {Z, Z, Z});

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
